rr_arbiter: RTL and testbench
=============================

Name: rr_arbiter

Overview:
- Round-robin arbiter that sits directly upstream of the one-hot-to-binary encoder.
- Takes up to WIDTH request lines and produces a registered, strictly one-hot grant vector plus a grant_valid strobe.
- grant drives the encoder's one-hot input; grant_valid drives the encoder's enable.
- Guarantees the encoder never sees a multi-hot input and gives fair, starvation-free access with an optional hold timeout.

Parameters:
- WIDTH, 8, number of requesters; integer >= 2.
- MAX_HOLD, 16, maximum consecutive cycles one grant may be held; 0 disables the timeout.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- req  input  WIDTH  per-requester request level; bit i high means requester i wants access.
- release  input  1  single-cycle pulse from the current owner ending its grant.
- grant  output  WIDTH  registered one-hot grant; all zero when no grant is held.
- grant_valid  output  1  registered; always equals |grant.
- timeout  output  1  registered one-cycle pulse; the grant just ended because MAX_HOLD expired.

Behaviour:
- Reset: one clock, one reset, synchronous and active-high.
  - On any clk edge with reset=1: grant=0, grant_valid=0, timeout=0, state=IDLE, ptr=0, hold_cnt=0.
  - Reset overrides every other input, including reset asserted mid-grant.
- Internal state:
  - 2-state FSM, IDLE and GRANT.
  - ptr, $clog2(WIDTH) bits: the highest-priority index.
  - hold_cnt, wide enough to hold MAX_HOLD.
- IDLE:
  - req==0: remain in IDLE; outputs stay zero.
  - req!=0: select the first set bit scanning ptr, ptr+1, ..., WIDTH-1, 0, ..., ptr-1.
  - Next edge: grant=one-hot of the selected index g, grant_valid=1, hold_cnt=1, state=GRANT.
  - Latency from req to grant is 1 cycle.
- GRANT end condition: end = release OR !req[g] OR (MAX_HOLD!=0 AND hold_cnt==MAX_HOLD).
- GRANT, end=0: grant held unchanged; hold_cnt increments.
- GRANT, end=1, at the next edge:
  - grant=0, grant_valid=0, state=IDLE, ptr=(g+1) mod WIDTH.
  - timeout=1 only if the timeout term was the sole cause of the end, i.e. release=0 and req[g]=1.
- Revoke-to-regrant gap: exactly one cycle with grant==0 between consecutive grants.
  - The encoder therefore never sees a direct one-hot to one-hot switch.
- Timeout length: with MAX_HOLD=N, a continuously held grant is visible for exactly N cycles.
- Wrap-around: g=WIDTH-1 sets ptr=0.
- release while in IDLE: ignored.
- Simultaneous release and new requests: release wins. Arbitration happens in the following IDLE cycle using the updated ptr.
- Invariants:
  - grant is always zero or exactly one-hot.
  - grant changes only on the IDLE->GRANT and GRANT->IDLE transitions.
  - req changes on bits other than g during GRANT have no effect.
- timeout is high for exactly one cycle, coincident with the first cycle of grant==0.

Test Plan:
- Reset check: hold reset 2 cycles with req=8'hFF. grant=8'h00, grant_valid=0, timeout=0 throughout; first grant is 8'b00000001 one cycle after reset drops.
- Basic arbitration: req=8'b00000101 from cycle 0, release pulse in cycle 3.
  - grant=8'b00000001 in cycles 1-3, 0 in cycle 4, 8'b00000100 from cycle 5.
- Wrap-around: drive ptr to 7 by granting requester 6, then req=8'b10000001.
  - grant=8'b10000000 first; after release, grant=8'b00000001.
- Timeout (MAX_HOLD=4): req=8'b00001000 held, release never pulsed.
  - grant=8'b00001000 for exactly 4 cycles, then grant=0 with timeout=1 for 1 cycle, then re-grant to bit 3.
- Request drop: grant=8'b00100000 active, req[5] deasserted.
  - grant=0 next cycle, timeout=0, ptr=6; next grant picks the lowest set bit at or after 6.
- Reset mid-grant: grant=8'b01000000 active, reset pulsed 1 cycle.
  - grant=0 at that edge; afterwards req=8'b01000001 yields grant=8'b00000001, confirming ptr=0.

Source files
------------

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin arbiter with one-hot registered grant and hold timeout
// Feeds a one-hot-to-binary encoder: grant is never multi-hot and always has a one-cycle gap between owners.
module rr_arbiter #(
  parameter int WIDTH    = 8,
  parameter int MAX_HOLD = 16
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [WIDTH-1:0] i_req,
  input  logic             i_release,
  output logic [WIDTH-1:0] o_grant,
  output logic             o_grant_valid,
  output logic             o_timeout
);

  localparam int PW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int HW = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);

  typedef enum logic {S_IDLE, S_GRANT} state_t;

  state_t           r_state, w_state_nxt;
  logic [PW-1:0]    r_ptr, w_ptr_nxt;
  logic [PW-1:0]    r_idx, w_idx_nxt;
  logic [HW-1:0]    r_hold, w_hold_nxt;
  logic [WIDTH-1:0] r_grant, w_grant_nxt;
  logic             r_grant_valid, r_timeout, w_timeout_nxt;

  logic             w_found;
  logic [PW-1:0]    w_sel;
  logic             w_hold_expired;
  logic             w_end;
  int               w_j;

  // Rotating priority scan starting at r_ptr; the first hit wins.
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    w_j     = 0;
    for (int i = 0; i < WIDTH; i++) begin
      w_j = (int'(r_ptr) + i) % WIDTH;
      if (!w_found && i_req[w_j]) begin
        w_found = 1'b1;
        w_sel   = PW'(w_j);
      end
    end
  end

  assign w_hold_expired = (MAX_HOLD != 0) && (r_hold == HW'(MAX_HOLD));
  assign w_end          = i_release || !i_req[r_idx] || w_hold_expired;

  always_comb begin
    w_state_nxt   = r_state;
    w_ptr_nxt     = r_ptr;
    w_idx_nxt     = r_idx;
    w_hold_nxt    = r_hold;
    w_grant_nxt   = r_grant;
    w_timeout_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_grant_nxt = '0;
        if (w_found) begin
          w_state_nxt = S_GRANT;
          w_idx_nxt   = w_sel;
          w_hold_nxt  = HW'(1);
          w_grant_nxt = {{(WIDTH-1){1'b0}}, 1'b1} << w_sel;
        end
      end
      S_GRANT: begin
        if (w_end) begin
          w_state_nxt   = S_IDLE;
          w_grant_nxt   = '0;
          w_ptr_nxt     = PW'((int'(r_idx) + 1) % WIDTH);
          // Flag a timeout only when the hold limit alone ended the grant.
          w_timeout_nxt = w_hold_expired && !i_release && i_req[r_idx];
        end else begin
          w_hold_nxt = r_hold + HW'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_grant_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state       <= S_IDLE;
      r_ptr         <= '0;
      r_idx         <= '0;
      r_hold        <= '0;
      r_grant       <= '0;
      r_grant_valid <= 1'b0;
      r_timeout     <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_ptr         <= w_ptr_nxt;
      r_idx         <= w_idx_nxt;
      r_hold        <= w_hold_nxt;
      r_grant       <= w_grant_nxt;
      r_grant_valid <= |w_grant_nxt;
      r_timeout     <= w_timeout_nxt;
    end
  end

  assign o_grant       = r_grant;
  assign o_grant_valid = r_grant_valid;
  assign o_timeout     = r_timeout;

endmodule

// File: tb/tb_rr_arbiter.sv
// tb/tb_rr_arbiter.sv - directed bench for rr_arbiter (WIDTH=8, MAX_HOLD=4)
module tb_rr_arbiter;

  logic       clk;
  logic       reset;
  logic [7:0] req;
  logic       rel;
  logic [7:0] grant;
  logic       grant_valid;
  logic       timeout;

  int n_cmp = 0;
  int n_err = 0;

  rr_arbiter #(.WIDTH(8), .MAX_HOLD(4)) dut (
    .i_clk         (clk),
    .i_reset       (reset),
    .i_req         (req),
    .i_release     (rel),
    .o_grant       (grant),
    .o_grant_valid (grant_valid),
    .o_timeout     (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [7:0] g, input logic v, input logic t);
    chk({tag, ".grant"}, grant, g);
    chk({tag, ".valid"}, {7'd0, grant_valid}, {7'd0, v});
    chk({tag, ".timeout"}, {7'd0, timeout}, {7'd0, t});
  endtask

  initial begin
    reset = 1'b1;
    req   = 8'hFF;
    rel   = 1'b0;

    // Reset held two cycles with all requests asserted.
    tick(); chk_all("rst0", 8'h00, 1'b0, 1'b0);
    tick(); chk_all("rst1", 8'h00, 1'b0, 1'b0);
    reset = 1'b0;
    tick(); chk_all("first", 8'h01, 1'b1, 1'b0);
    req = 8'h00;
    tick(); chk_all("drop0", 8'h00, 1'b0, 1'b0);

    // Basic arbitration from ptr=0.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    req   = 8'b0000_0101;
    tick(); chk_all("basic_c1", 8'h01, 1'b1, 1'b0);
    tick(); chk_all("basic_c2", 8'h01, 1'b1, 1'b0);
    tick(); chk_all("basic_c3", 8'h01, 1'b1, 1'b0);
    rel = 1'b1;
    tick(); chk_all("basic_c4", 8'h00, 1'b0, 1'b0);
    rel = 1'b0;
    tick(); chk_all("basic_c5", 8'h04, 1'b1, 1'b0);
    req = 8'h00;
    tick(); chk_all("basic_end", 8'h00, 1'b0, 1'b0);

    // Wrap-around: ptr=3, grant 6 to move ptr to 7.
    req = 8'b0100_0000;
    tick(); chk_all("wrap_g6", 8'h40, 1'b1, 1'b0);
    rel = 1'b1;
    tick(); chk_all("wrap_gap0", 8'h00, 1'b0, 1'b0);
    rel = 1'b0;
    req = 8'b1000_0001;
    tick(); chk_all("wrap_g7", 8'h80, 1'b1, 1'b0);
    rel = 1'b1;
    tick(); chk_all("wrap_gap1", 8'h00, 1'b0, 1'b0);
    rel = 1'b0;
    tick(); chk_all("wrap_g0", 8'h01, 1'b1, 1'b0);
    req = 8'h00;
    tick(); chk_all("wrap_end", 8'h00, 1'b0, 1'b0);

    // Timeout: MAX_HOLD=4, no release.
    req = 8'b0000_1000;
    tick(); chk_all("to_h1", 8'h08, 1'b1, 1'b0);
    tick(); chk_all("to_h2", 8'h08, 1'b1, 1'b0);
    tick(); chk_all("to_h3", 8'h08, 1'b1, 1'b0);
    tick(); chk_all("to_h4", 8'h08, 1'b1, 1'b0);
    tick(); chk_all("to_pulse", 8'h00, 1'b0, 1'b1);
    tick(); chk_all("to_regrant", 8'h08, 1'b1, 1'b0);
    rel = 1'b1;
    tick(); chk_all("to_rel", 8'h00, 1'b0, 1'b0);
    rel = 1'b0;

    // Release in IDLE is ignored.
    req = 8'h00;
    rel = 1'b1;
    tick(); chk_all("idle_rel", 8'h00, 1'b0, 1'b0);
    rel = 1'b0;

    // Request drop: ptr=4, grant 5, then drop req[5].
    req = 8'b1110_0000;
    tick(); chk_all("drop_g5", 8'h20, 1'b1, 1'b0);
    req = 8'b1000_0011;
    tick(); chk_all("drop_gap", 8'h00, 1'b0, 1'b0);
    tick(); chk_all("drop_g7", 8'h80, 1'b1, 1'b0);
    rel = 1'b1;
    tick(); chk_all("drop_rel", 8'h00, 1'b0, 1'b0);
    rel = 1'b0;

    // Reset mid-grant restores ptr=0.
    req = 8'b0100_0000;
    tick(); chk_all("mid_g6", 8'h40, 1'b1, 1'b0);
    reset = 1'b1;
    tick(); chk_all("mid_rst", 8'h00, 1'b0, 1'b0);
    reset = 1'b0;
    req   = 8'b0100_0001;
    tick(); chk_all("mid_g0", 8'h01, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
